// File: rtl/adc_frame_packer.sv
// adc_frame_packer
// Packs the free-running 12-bit ADC sample stream into framed 16-bit words
// for the SDRAM controller's user write FIFO. Every frame is:
//   SYNC_WORD, sequence number, FRAME_LEN sample words [, CRC-16 word]
// A full FIFO never stalls the ADC. It aborts the frame in progress, and the
// host resynchronises on the next SYNC_WORD.
//
// Optional feature: define FRAME_CRC_EN to append a CRC-16/CCITT-FALSE word
// (poly 0x1021, init 0xFFFF) covering the sequence word and all sample words.
//
// Parameters:
//   FRAME_LEN   samples per frame (8..1020)
//   SYNC_WORD   first word of every frame
// Ports:
//   clk_i        ADC sample clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   en_i         capture enable, sampled at frame boundaries only
//   ad_data_i    ADC sample, valid every cycle
//   ad_otr_i     ADC out-of-range flag, aligned with ad_data_i
//   full_i       SDRAM write FIFO full
//   wr_en_o      write strobe to the FIFO
//   wr_data_o    write word
//   frame_cnt_o  sequence number of the next frame header
//   drop_cnt_o   aborted-frame count, saturating
//   busy_o       high while not IDLE
module adc_frame_packer #(
    parameter int unsigned FRAME_LEN = 510,
    parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic [11:0] ad_data_i,
    input  logic        ad_otr_i,
    input  logic        full_i,
    output logic        wr_en_o,
    output logic [15:0] wr_data_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] drop_cnt_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_SMP  = 3'd3
`ifdef FRAME_CRC_EN
        , S_CRC = 3'd4
`endif
    } state_t;

    state_t           state_q;
    state_t           state_nx;
    logic [11:0]      data_r;
    logic             otr_r;
    logic [CNT_W-1:0] smp_cnt_q;
    logic             wr_en_c;
    logic [15:0]      wr_data_c;
    logic [15:0]      sample_word_c;
    logic             abort_c;

    // Input stage: sample every cycle, regardless of state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_r <= 12'h000;
            otr_r  <= 1'b0;
        end else begin
            data_r <= ad_data_i;
            otr_r  <= ad_otr_i;
        end
    end

    assign sample_word_c = {otr_r, smp_cnt_q[2:0], data_r};

    // A full FIFO in any framing state kills that cycle's word and the frame.
    assign abort_c = full_i && (state_q != S_IDLE);

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state logic; frame end chains straight into HDR0 when allowed.
    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_IDLE: begin
                if (en_i && !full_i) begin
                    state_nx = S_HDR0;
                end
            end
            S_HDR0: begin
                state_nx = full_i ? S_IDLE : S_HDR1;
            end
            S_HDR1: begin
                state_nx = full_i ? S_IDLE : S_SMP;
            end
            S_SMP: begin
                if (full_i) begin
                    state_nx = S_IDLE;
                end else if (smp_cnt_q == LAST_IDX) begin
`ifdef FRAME_CRC_EN
                    state_nx = S_CRC;
`else
                    state_nx = en_i ? S_HDR0 : S_IDLE;
`endif
                end
            end
`ifdef FRAME_CRC_EN
            S_CRC: begin
                if (full_i) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = en_i ? S_HDR0 : S_IDLE;
                end
            end
`endif
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

`ifdef FRAME_CRC_EN
    logic [15:0] crc_q;

    // One CRC-16/CCITT-FALSE update over a full 16-bit word, MSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    // Output word selection; the last word is held when nothing is written.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_data_c = wr_data_o;
        case (state_q)
            S_HDR0: begin
                wr_en_c   = !full_i;
                wr_data_c = SYNC_WORD;
            end
            S_HDR1: begin
                wr_en_c   = !full_i;
                wr_data_c = frame_cnt_o;
            end
            S_SMP: begin
                wr_en_c   = !full_i;
                wr_data_c = sample_word_c;
            end
`ifdef FRAME_CRC_EN
            S_CRC: begin
                wr_en_c   = !full_i;
                wr_data_c = crc_q;
            end
`endif
            default: begin
                wr_en_c = 1'b0;
            end
        endcase
    end

    // Registered outputs and counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_en_o     <= 1'b0;
            wr_data_o   <= 16'h0000;
            frame_cnt_o <= 16'h0000;
            drop_cnt_o  <= 16'h0000;
            busy_o      <= 1'b0;
            smp_cnt_q   <= '0;
        end else begin
            wr_en_o   <= wr_en_c;
            wr_data_o <= wr_data_c;
            busy_o    <= (state_nx != S_IDLE);
            // The sequence number advances in HDR1 even if that word is lost,
            // so an abort after HDR0 leaves a visible gap for the host.
            if (state_q == S_HDR1) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
                smp_cnt_q   <= '0;
            end else if (state_q == S_SMP) begin
                smp_cnt_q <= smp_cnt_q + CNT_W'(1);
            end
            if (abort_c && (drop_cnt_o != 16'hFFFF)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

`ifdef FRAME_CRC_EN
    // Running CRC over the sequence word and samples; SYNC_WORD is excluded.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= 16'hFFFF;
        end else if (state_q == S_HDR0) begin
            crc_q <= 16'hFFFF;
        end else if ((state_q == S_HDR1) && !full_i) begin
            crc_q <= crc16_step(crc_q, frame_cnt_o);
        end else if ((state_q == S_SMP) && !full_i) begin
            crc_q <= crc16_step(crc_q, sample_word_c);
        end
    end
`endif

endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer with FRAME_LEN=8.
// Edge numbering restarts at 1 for the first rising edge after each reset
// release; the ramp value presented before edge c is 0x100 + c - 1.
module tb_adc_frame_packer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        en_i;
    logic [11:0] ad_data_i;
    logic        ad_otr_i;
    logic        full_i;
    logic        wr_en_o;
    logic [15:0] wr_data_o;
    logic [15:0] frame_cnt_o;
    logic [15:0] drop_cnt_o;
    logic        busy_o;

    adc_frame_packer #(.FRAME_LEN(8), .SYNC_WORD(16'hA55A)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .en_i        (en_i),
        .ad_data_i   (ad_data_i),
        .ad_otr_i    (ad_otr_i),
        .full_i      (full_i),
        .wr_en_o     (wr_en_o),
        .wr_data_o   (wr_data_o),
        .frame_cnt_o (frame_cnt_o),
        .drop_cnt_o  (drop_cnt_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    logic [15:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;
    int cyc   = 0;
    logic use_zero = 1'b0;

    // Monitor: every write the DUT makes must match the head of the queue.
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_n_i && wr_en_o) begin
                n_wr++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got %h, expected no write", wr_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_data_o !== e) begin
                        n_err++;
                        $display("FAIL wr_data (write #%0d): got %h, expected %h", n_wr, wr_data_o, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] ramp(input int c);
        return 12'(32'h100 + c - 1);
    endfunction

    task automatic do_reset();
        rst_n_i   = 1'b0;
        en_i      = 1'b0;
        full_i    = 1'b0;
        ad_otr_i  = 1'b0;
        ad_data_i = 12'h000;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cyc = 0;
    endtask

    // Drive edges cyc+1..last_edge; en high through en_last, full on full_edge,
    // otr with data 0x123 on otr_edge.
    task automatic run_span(input int last_edge, input int en_last, input int full_edge, input int otr_edge);
        int e;
        while (cyc < last_edge) begin
            e = cyc + 1;
            en_i      = (e <= en_last);
            full_i    = (e == full_edge);
            ad_otr_i  = (e == otr_edge);
            ad_data_i = use_zero ? 12'h000 : ((e == otr_edge) ? 12'h123 : ramp(e));
            @(posedge clk_i);
            @(negedge clk_i);
            cyc = e;
        end
    endtask

    task automatic push_hdr(input logic [15:0] seq);
        exp_q.push_back(16'hA55A);
        exp_q.push_back(seq);
    endtask

    task automatic push_smp(input int first_val);
        for (int j = 0; j < 8; j++) begin
            exp_q.push_back({1'b0, 3'(j), 12'(first_val + j)});
        end
    endtask

`ifdef FRAME_CRC_EN
    function automatic logic [15:0] crc_model(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            c = (c[15] ^ d[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction
`endif

    initial begin
        int w0;
        do_reset();
        rst_n_i = 1'b0;
        #1;
        chk("reset wr_en", 16'(wr_en_o), 16'h0);
        chk("reset wr_data", wr_data_o, 16'h0000);
        chk("reset frame_cnt", frame_cnt_o, 16'h0000);
        chk("reset drop_cnt", drop_cnt_o, 16'h0000);
        chk("reset busy", 16'(busy_o), 16'h0);

`ifdef FRAME_CRC_EN
        begin
            logic [15:0] c;
            do_reset();
            use_zero = 1'b1;
            w0 = n_wr;
            push_hdr(16'h0000);
            c = crc_model(16'hFFFF, 16'h0000);
            for (int j = 0; j < 8; j++) begin
                exp_q.push_back({1'b0, 3'(j), 12'h000});
                c = crc_model(c, {1'b0, 3'(j), 12'h000});
            end
            exp_q.push_back(c);
            run_span(13, 5, 0, 0);
            chk("crc frame words", 16'(n_wr - w0), 16'd11);
            chk("crc idle wr_en", 16'(wr_en_o), 16'h0);
            chk("crc frame_cnt", frame_cnt_o, 16'h0001);
            use_zero = 1'b0;
        end
`else
        // Two back-to-back frames, en dropped in SMP of frame 1.
        do_reset();
        w0 = n_wr;
        push_hdr(16'h0000); push_smp(32'h102);
        push_hdr(16'h0001); push_smp(32'h10C);
        run_span(21, 14, 0, 0);
        chk("b2b write count", 16'(n_wr - w0), 16'd20);
        chk("b2b busy at end", 16'(busy_o), 16'h0);
        run_span(22, 14, 0, 0);
        chk("b2b idle wr_en", 16'(wr_en_o), 16'h0);
        chk("b2b frame_cnt", frame_cnt_o, 16'h0002);
        chk("b2b drop_cnt", drop_cnt_o, 16'h0000);
        run_span(25, 14, 0, 0);

        // OTR at sample 2 and en dropped during frame 0.
        do_reset();
        push_hdr(16'h0000);
        exp_q.push_back(16'h0102); exp_q.push_back(16'h1103);
        exp_q.push_back(16'hA123); exp_q.push_back(16'h3105);
        exp_q.push_back(16'h4106); exp_q.push_back(16'h5107);
        exp_q.push_back(16'h6108); exp_q.push_back(16'h7109);
        run_span(12, 5, 0, 5);
        chk("otr idle wr_en", 16'(wr_en_o), 16'h0);
        chk("otr idle busy", 16'(busy_o), 16'h0);
        chk("otr frame_cnt", frame_cnt_o, 16'h0001);

        // full pulse in SMP of frame 1: abort, gap in sequence.
        do_reset();
        push_hdr(16'h0000); push_smp(32'h102);
        push_hdr(16'h0001);
        exp_q.push_back(16'h010C); exp_q.push_back(16'h110D);
        push_hdr(16'h0002); push_smp(32'h112);
        run_span(16, 21, 16, 0);
        chk("abort smp wr_en", 16'(wr_en_o), 16'h0);
        chk("abort smp drop_cnt", drop_cnt_o, 16'h0001);
        chk("abort smp busy", 16'(busy_o), 16'h0);
        chk("abort smp frame_cnt", frame_cnt_o, 16'h0002);
        run_span(28, 21, 16, 0);
        chk("after abort frame_cnt", frame_cnt_o, 16'h0003);
        chk("after abort wr_en", 16'(wr_en_o), 16'h0);

        // full in HDR0: sequence number is reused.
        do_reset();
        push_hdr(16'h0000); push_smp(32'h104);
        run_span(2, 5, 2, 0);
        chk("abort hdr0 wr_en", 16'(wr_en_o), 16'h0);
        chk("abort hdr0 drop_cnt", drop_cnt_o, 16'h0001);
        chk("abort hdr0 frame_cnt", frame_cnt_o, 16'h0000);
        run_span(14, 5, 2, 0);
        chk("hdr0 reuse frame_cnt", frame_cnt_o, 16'h0001);

        // Reset mid-SMP.
        do_reset();
        push_hdr(16'h0000);
        exp_q.push_back(16'h0102); exp_q.push_back(16'h1103); exp_q.push_back(16'h2104);
        run_span(6, 20, 0, 0);
        rst_n_i = 1'b0;
        #1;
        chk("midrst wr_en", 16'(wr_en_o), 16'h0);
        chk("midrst wr_data", wr_data_o, 16'h0000);
        chk("midrst frame_cnt", frame_cnt_o, 16'h0000);
        chk("midrst busy", 16'(busy_o), 16'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cyc = 0;
        push_hdr(16'h0000); push_smp(32'h102);
        run_span(12, 5, 0, 0);
        chk("post-reset frame_cnt", frame_cnt_o, 16'h0001);
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk_i);
        end
        chk("leftover expected writes", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
